issue_wakeup: RTL and testbench
===============================

Name: issue_wakeup

Overview:
- Consumer end of the issue queue: takes the two uops issued per cycle and models their execution latency.
- Produces the 4-slot wakeup bus (`i_wdest4x` of the queue) plus completion tags for the ROB.
- Per issue lane:
  - a 1-cycle fast path drives slots 0/1;
  - a non-pipelined multi-cycle unit (MUL/DIV) drives slots 2/3.
- Honours branch kill on in-flight uops.

Parameters:
- WIDTH_REG, 3, physical register index width
- WIDTH_TAG, 3, ROB tag width
- WIDTH_BRM, 3, branch mask width
- LAT_MUL, 3, MUL latency in cycles (>=2)
- LAT_DIV, 8, DIV latency in cycles (>LAT_MUL)
- WIDTH (derived), 7+WIDTH_BRM+WIDTH_TAG+3*WIDTH_REG+3, uop width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_inst1  in  WIDTH  uop lane 1: {UOP[6:0],BrM,Tag,prd,pr2,pr1,val,p2,p1}
- i_inst2  in  WIDTH  uop lane 2
- i_ready1  in  1  lane 1 issue strobe
- i_ready2  in  1  lane 2 issue strobe
- i_BrKill  in  WIDTH_BRM  branch kill mask, valid this cycle
- o_wdest4x  out  4*WIDTH_REG  wakeup prd; slot0=lane1 fast, slot1=lane2 fast, slot2=lane1 slow, slot3=lane2 slow; 0 = idle
- o_tag4x  out  4*WIDTH_TAG  completion tags, same slot order
- o_tagv  out  4  completion valid per slot
- o_busy1  out  1  lane 1 slow unit occupied
- o_busy2  out  1  lane 2 slow unit occupied
- o_overflow  out  1  sticky: slow uop issued while unit busy

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst_n, synchronous, active-low.
- Reset values: all outputs 0; slow units idle; o_overflow cleared.
  - Reset mid-operation aborts in-flight uops without emitting wakeups.
- Accept condition, per lane: accept = i_readyN & val (bit 2).
- Kill test for a uop: killed = |(BrM & i_BrKill).
- Latency classes, from UOP[1:0]:
  - 00 and 01: fast, latency 1.
  - 10: MUL, latency LAT_MUL.
  - 11: DIV, latency LAT_DIV.
- Fast path:
  - Accepted and not killed → next cycle slot N carries prd and tag, with tagv=1.
  - Otherwise slot is 0 and tagv=0.
  - prd==0 (no destination): wakeup slot stays 0, but tagv=1 (completion only).
- Slow unit, per lane (states IDLE, RUN):
  - IDLE + accepted slow uop + not killed → RUN.
    - Load counter = LAT-1, latch prd/tag/BrM; o_busyN=1 from next cycle.
  - RUN: counter decrements each cycle.
  - In the cycle counter==1, the next edge drives slot 2/3 with prd/tag/tagv=1 for exactly one cycle and returns to IDLE.
  - Net result: wakeup is visible LAT cycles after the issue edge.
  - RUN + i_BrKill hitting the latched BrM → IDLE next cycle; no wakeup, no tagv.
  - RUN + new accepted slow uop on the same lane → uop dropped, o_overflow set (sticky until reset). The queue is responsible for gating on o_busy.
  - Completion cycle + new slow issue: still an overflow. o_busy drops only after completion.
- Same-cycle events:
  - The fast path and the slow unit of the same lane may complete in the same cycle; they use distinct slots, so there is no conflict.
  - Kill applies to both incoming and in-flight uops in the same cycle.
  - Lanes are fully independent.
- Counter width: $clog2(LAT_DIV+1); no wrap.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package `uop_pkg`:
  - field offsets/widths for UOP, BrM, Tag, prd, pr2, pr1, val, p2, p1;
  - latency class encodings (LAT_FAST=2'b0x, MUL=2'b10, DIV=2'b11);
  - default widths.
- Sub-module `wakeup_lane`: one fast register plus slow FSM/counter, instantiated twice. The top only concatenates slots and ORs the overflow flags.

Test Plan:
- Reset: i_rst_n=0 for 2 cycles with i_ready1=1 and an ALU uop → o_wdest4x=0, o_tagv=0, busy=0 throughout and one cycle after release.
- Fast issue: lane1 UOP[1:0]=00, prd=5, Tag=3, BrM=001, i_BrKill=010 → next cycle slot0 prd=5, tag=3, o_tagv=0001; the cycle after, slot0=0.
- MUL/DIV together: lane1 MUL prd=6 (LAT_MUL=3), lane2 DIV prd=4 (LAT_DIV=8), same cycle → slot2=6 at issue+3 with tagv[2]=1; slot3=4 at issue+8; o_busy1 high 2 cycles, o_busy2 high 7 cycles.
- Kill in flight: lane2 DIV BrM=010, i_BrKill=010 pulsed at issue+4 → o_busy2 low at issue+5; slot3 never nonzero; o_tagv[3] never set.
- Overflow: lane1 DIV issued, then MUL issued while o_busy1=1 → o_overflow=1 and stays 1; DIV still completes at original time; MUL never emitted.
- val gating and no-dest: i_ready2=1 with val=0 → no output. Fast uop with prd=0 → slot1=0, o_tagv[1]=1.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared uop field layout and latency-class encodings for the issue back end.
// Layout, MSB first: {UOP[6:0], BrM, Tag, prd, pr2, pr1, val, p2, p1}.
package uop_pkg;

    localparam int WIDTH_REG_DEF = 3;
    localparam int WIDTH_TAG_DEF = 3;
    localparam int WIDTH_BRM_DEF = 3;
    localparam int LAT_MUL_DEF   = 3;
    localparam int LAT_DIV_DEF   = 8;

    localparam int UOP_W   = 7;
    localparam int POS_VAL = 2;
    localparam int POS_PR1 = 3;

    // UOP[1:0]: 2'b0x is the single-cycle class
    localparam logic [1:0] CLS_MUL = 2'b10;
    localparam logic [1:0] CLS_DIV = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } slow_state_e;

    function automatic int pos_prd(input int wr);
        return POS_PR1 + 2 * wr;
    endfunction

    function automatic int pos_tag(input int wr);
        return POS_PR1 + 3 * wr;
    endfunction

    function automatic int pos_brm(input int wr, input int wt);
        return pos_tag(wr) + wt;
    endfunction

    function automatic int pos_uop(input int wr, input int wt, input int wb);
        return pos_brm(wr, wt) + wb;
    endfunction

    function automatic int uop_width(input int wr, input int wt, input int wb);
        return pos_uop(wr, wt, wb) + UOP_W;
    endfunction

    function automatic logic is_slow(input logic [1:0] cls);
        return (cls == CLS_MUL) || (cls == CLS_DIV);
    endfunction

endpackage

// File: rtl/wakeup_lane.sv
// One issue lane: a 1-cycle fast result register plus a non-pipelined
// MUL/DIV unit modelled as an IDLE/RUN FSM with a latency counter.
module wakeup_lane
    import uop_pkg::*;
#(
    parameter int WIDTH_REG = WIDTH_REG_DEF,
    parameter int WIDTH_TAG = WIDTH_TAG_DEF,
    parameter int WIDTH_BRM = WIDTH_BRM_DEF,
    parameter int LAT_MUL   = LAT_MUL_DEF,
    parameter int LAT_DIV   = LAT_DIV_DEF,
    parameter int WIDTH     = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [WIDTH-1:0]     inst_i,
    input  logic                 ready_i,
    input  logic [WIDTH_BRM-1:0] brkill_i,
    output logic [WIDTH_REG-1:0] fast_prd_o,
    output logic [WIDTH_TAG-1:0] fast_tag_o,
    output logic                 fast_v_o,
    output logic [WIDTH_REG-1:0] slow_prd_o,
    output logic [WIDTH_TAG-1:0] slow_tag_o,
    output logic                 slow_v_o,
    output logic                 busy_o,
    output logic                 overflow_o
);

    localparam int CW    = $clog2(LAT_DIV + 1);
    localparam int P_PRD = pos_prd(WIDTH_REG);
    localparam int P_TAG = pos_tag(WIDTH_REG);
    localparam int P_BRM = pos_brm(WIDTH_REG, WIDTH_TAG);
    localparam int P_UOP = pos_uop(WIDTH_REG, WIDTH_TAG, WIDTH_BRM);

    logic [WIDTH_REG-1:0] prd;
    logic [WIDTH_TAG-1:0] tag;
    logic [WIDTH_BRM-1:0] brm;
    logic [1:0]           cls;
    logic                 accept, kill_new, kill_run, slow_new;
    logic                 unused_fields;

    assign prd      = inst_i[P_PRD +: WIDTH_REG];
    assign tag      = inst_i[P_TAG +: WIDTH_TAG];
    assign brm      = inst_i[P_BRM +: WIDTH_BRM];
    assign cls      = inst_i[P_UOP +: 2];
    assign accept   = ready_i & inst_i[POS_VAL];
    assign kill_new = |(brm & brkill_i);
    assign slow_new = accept & is_slow(cls);
    assign unused_fields = ^{inst_i[WIDTH-1:P_UOP+2], inst_i[P_PRD-1:POS_VAL+1],
                             inst_i[POS_VAL-1:0]};

    logic [WIDTH_REG-1:0] fast_prd_d, fast_prd_q;
    logic [WIDTH_TAG-1:0] fast_tag_d, fast_tag_q;
    logic                 fast_v_d, fast_v_q;

    always_comb begin
        fast_v_d   = accept & ~kill_new & ~is_slow(cls);
        fast_prd_d = '0;
        fast_tag_d = '0;
        if (fast_v_d) begin
            fast_prd_d = prd;
            fast_tag_d = tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fast_prd_q <= '0;
            fast_tag_q <= '0;
            fast_v_q   <= 1'b0;
        end else begin
            fast_prd_q <= fast_prd_d;
            fast_tag_q <= fast_tag_d;
            fast_v_q   <= fast_v_d;
        end
    end

    slow_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [WIDTH_REG-1:0] prd_q, slow_prd_q;
    logic [WIDTH_TAG-1:0] tag_q, slow_tag_q;
    logic [WIDTH_BRM-1:0] brm_q;
    logic                 slow_v_q, busy_q, ovf_q;

    assign kill_run = |(brm_q & brkill_i);

    // Kill of the in-flight uop takes priority over its completion edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
            slow_v_q   <= 1'b0;
            slow_prd_q <= '0;
            slow_tag_q <= '0;
        end else begin
            slow_v_q   <= 1'b0;
            slow_prd_q <= '0;
            slow_tag_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (slow_new && !kill_new) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= (cls == CLS_DIV) ? CW'(LAT_DIV - 1) : CW'(LAT_MUL - 1);
                        prd_q   <= prd;
                        tag_q   <= tag;
                        brm_q   <= brm;
                    end
                end
                ST_RUN: begin
                    if (slow_new) begin
                        ovf_q <= 1'b1;
                    end
                    if (kill_run) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CW'(1)) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        slow_v_q   <= 1'b1;
                        slow_prd_q <= prd_q;
                        slow_tag_q <= tag_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fast_prd_o = fast_prd_q;
    assign fast_tag_o = fast_tag_q;
    assign fast_v_o   = fast_v_q;
    assign slow_prd_o = slow_prd_q;
    assign slow_tag_o = slow_tag_q;
    assign slow_v_o   = slow_v_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/issue_wakeup.sv
// Issue-queue consumer: two lanes of fast + MUL/DIV latency modelling feeding
// the 4-slot wakeup bus and ROB completion tags.
module issue_wakeup
    import uop_pkg::*;
#(
    parameter int WIDTH_REG = WIDTH_REG_DEF,
    parameter int WIDTH_TAG = WIDTH_TAG_DEF,
    parameter int WIDTH_BRM = WIDTH_BRM_DEF,
    parameter int LAT_MUL   = LAT_MUL_DEF,
    parameter int LAT_DIV   = LAT_DIV_DEF,
    parameter int WIDTH     = uop_width(WIDTH_REG, WIDTH_TAG, WIDTH_BRM)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_inst1,
    input  logic [WIDTH-1:0]       i_inst2,
    input  logic                   i_ready1,
    input  logic                   i_ready2,
    input  logic [WIDTH_BRM-1:0]   i_BrKill,
    output logic [4*WIDTH_REG-1:0] o_wdest4x,
    output logic [4*WIDTH_TAG-1:0] o_tag4x,
    output logic [3:0]             o_tagv,
    output logic                   o_busy1,
    output logic                   o_busy2,
    output logic                   o_overflow
);

    logic [WIDTH_REG-1:0] fprd [2];
    logic [WIDTH_REG-1:0] sprd [2];
    logic [WIDTH_TAG-1:0] ftag [2];
    logic [WIDTH_TAG-1:0] stag [2];
    logic [1:0]           fv, sv, busy, ovf;
    logic [WIDTH-1:0]     inst [2];
    logic [1:0]           ready;

    assign inst[0]  = i_inst1;
    assign inst[1]  = i_inst2;
    assign ready    = {i_ready2, i_ready1};

    for (genvar l = 0; l < 2; l++) begin : g_lane
        wakeup_lane #(
            .WIDTH_REG(WIDTH_REG),
            .WIDTH_TAG(WIDTH_TAG),
            .WIDTH_BRM(WIDTH_BRM),
            .LAT_MUL  (LAT_MUL),
            .LAT_DIV  (LAT_DIV),
            .WIDTH    (WIDTH)
        ) u_lane (
            .clk_i     (i_clk),
            .rst_n_i   (i_rst_n),
            .inst_i    (inst[l]),
            .ready_i   (ready[l]),
            .brkill_i  (i_BrKill),
            .fast_prd_o(fprd[l]),
            .fast_tag_o(ftag[l]),
            .fast_v_o  (fv[l]),
            .slow_prd_o(sprd[l]),
            .slow_tag_o(stag[l]),
            .slow_v_o  (sv[l]),
            .busy_o    (busy[l]),
            .overflow_o(ovf[l])
        );
    end

    assign o_wdest4x  = {sprd[1], sprd[0], fprd[1], fprd[0]};
    assign o_tag4x    = {stag[1], stag[0], ftag[1], ftag[0]};
    assign o_tagv     = {sv[1], sv[0], fv[1], fv[0]};
    assign o_busy1    = busy[0];
    assign o_busy2    = busy[1];
    assign o_overflow = |ovf;

endmodule

// File: tb/tb_issue_wakeup.sv
// Bench for issue_wakeup: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a completion-time model.
module tb_issue_wakeup;

    localparam int R = 3, T = 3, B = 3, LMUL = 3, LDIV = 8;
    localparam int W = 7 + B + T + 3 * R + 3;
    localparam int O_PRD = 3 + 2 * R, O_TAG = 3 + 3 * R, O_BRM = O_TAG + T, O_UOP = O_BRM + B;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   inst1, inst2;
    logic           ready1, ready2;
    logic [B-1:0]   brkill;
    logic [4*R-1:0] wdest;
    logic [4*T-1:0] tag4;
    logic [3:0]     tagv;
    logic           busy1, busy2, ovf;

    issue_wakeup #(.WIDTH_REG(R), .WIDTH_TAG(T), .WIDTH_BRM(B),
                   .LAT_MUL(LMUL), .LAT_DIV(LDIV)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst1(inst1), .i_inst2(inst2),
        .i_ready1(ready1), .i_ready2(ready2), .i_BrKill(brkill),
        .o_wdest4x(wdest), .o_tag4x(tag4), .o_tagv(tagv),
        .o_busy1(busy1), .o_busy2(busy2), .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [6:0] uop, input logic [B-1:0] brm,
                                        input logic [T-1:0] tag, input logic [R-1:0] prd,
                                        input logic val);
        return {uop, brm, tag, prd, 3'b101, 3'b011, val, 2'b11};
    endfunction

    // Model: each slow unit holds at most one uop with an absolute edge
    // number at which its wakeup is launched.
    bit             pend [2];
    int             due  [2];
    logic [R-1:0]   m_prd [2];
    logic [T-1:0]   m_tag [2];
    logic [B-1:0]   m_brm [2];
    bit             m_ovf;
    int             ecnt = 0;
    logic [4*R-1:0] e_wdest;
    logic [4*T-1:0] e_tag;
    logic [3:0]     e_tagv;
    logic           e_busy1, e_busy2, e_ovf;

    task automatic model_update();
        logic [R-1:0] fp [2], sp [2];
        logic [T-1:0] ft [2], st [2];
        logic         fvv [2], svv [2];
        for (int l = 0; l < 2; l++) begin
            logic [W-1:0] in;
            logic         acc, kin, slow;
            logic [1:0]   cls;
            in   = (l == 0) ? inst1 : inst2;
            acc  = ((l == 0) ? ready1 : ready2) & in[2];
            kin  = |(in[O_BRM +: B] & brkill);
            cls  = in[O_UOP +: 2];
            slow = (cls == 2'b10) || (cls == 2'b11);
            fvv[l] = 0; fp[l] = '0; ft[l] = '0;
            svv[l] = 0; sp[l] = '0; st[l] = '0;
            if (!rst_n) begin
                pend[l] = 0;
            end else begin
                if (acc && !kin && !slow) begin
                    fvv[l] = 1; fp[l] = in[O_PRD +: R]; ft[l] = in[O_TAG +: T];
                end
                if (pend[l]) begin
                    if (acc && slow) m_ovf = 1;
                    if (|(m_brm[l] & brkill)) begin
                        pend[l] = 0;
                    end else if (ecnt == due[l]) begin
                        svv[l] = 1; sp[l] = m_prd[l]; st[l] = m_tag[l];
                        pend[l] = 0;
                    end
                end else if (acc && slow && !kin) begin
                    pend[l]  = 1;
                    due[l]   = ecnt + ((cls == 2'b11) ? LDIV : LMUL) - 1;
                    m_prd[l] = in[O_PRD +: R];
                    m_tag[l] = in[O_TAG +: T];
                    m_brm[l] = in[O_BRM +: B];
                end
            end
        end
        if (!rst_n) m_ovf = 0;
        e_wdest = {sp[1], sp[0], fp[1], fp[0]};
        e_tag   = {st[1], st[0], ft[1], ft[0]};
        e_tagv  = {svv[1], svv[0], fvv[1], fvv[0]};
        e_busy1 = pend[0];
        e_busy2 = pend[1];
        e_ovf   = m_ovf;
        ecnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        inst1 = '0; inst2 = '0; ready1 = 0; ready2 = 0; brkill = '0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_wdest", {20'd0, wdest}, {20'd0, e_wdest});
            chk("model_tag", {20'd0, tag4}, {20'd0, e_tag});
            chk("model_tagv", {28'd0, tagv}, {28'd0, e_tagv});
            chk("model_busy", {30'd0, busy2, busy1}, {30'd0, e_busy2, e_busy1});
            chk("model_ovf", {31'd0, ovf}, {31'd0, e_ovf});
        end
    end

    initial begin
        // reset held with a live ALU uop on lane 1
        rst_n = 0; idle();
        ready1 = 1; inst1 = mk(7'h00, 3'b000, 3'd2, 3'd5, 1'b1);
        step();
        chk_en = 1;
        step();
        chk("rst_wdest", {20'd0, wdest}, 0);
        chk("rst_tagv", {28'd0, tagv}, 0);
        chk("rst_busy", {30'd0, busy2, busy1}, 0);
        rst_n = 1; idle();
        step();
        chk("rel_wdest", {20'd0, wdest}, 0);
        chk("rel_tagv", {28'd0, tagv}, 0);

        // fast issue, kill mask misses BrM
        ready1 = 1; inst1 = mk(7'h00, 3'b001, 3'd3, 3'd5, 1'b1); brkill = 3'b010;
        step(); idle();
        chk("fast_slot0", {29'd0, wdest[2:0]}, 5);
        chk("fast_tag0", {29'd0, tag4[2:0]}, 3);
        chk("fast_tagv", {28'd0, tagv}, 4'b0001);
        step();
        chk("fast_clear", {20'd0, wdest}, 0);
        chk("fast_clrv", {28'd0, tagv}, 0);

        // MUL on lane 1 and DIV on lane 2 in the same cycle
        ready1 = 1; inst1 = mk(7'h02, 3'b000, 3'd1, 3'd6, 1'b1);
        ready2 = 1; inst2 = mk(7'h03, 3'b000, 3'd2, 3'd4, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            step(); idle();
            chk($sformatf("md_busy1_%0d", i), {31'd0, busy1}, (i <= LMUL - 1) ? 1 : 0);
            chk($sformatf("md_busy2_%0d", i), {31'd0, busy2}, (i <= LDIV - 1) ? 1 : 0);
            chk($sformatf("md_slot2_%0d", i), {29'd0, wdest[8:6]}, (i == LMUL) ? 6 : 0);
            chk($sformatf("md_slot3_%0d", i), {29'd0, wdest[11:9]}, (i == LDIV) ? 4 : 0);
            chk($sformatf("md_tagv_%0d", i), {28'd0, tagv},
                {28'd0, (i == LDIV) ? 1'b1 : 1'b0, (i == LMUL) ? 1'b1 : 1'b0, 2'b00});
        end

        // in-flight DIV killed at issue+4
        ready2 = 1; inst2 = mk(7'h03, 3'b010, 3'd5, 3'd7, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(); idle();
            if (i == 4) brkill = 3'b010;
            chk($sformatf("kill_busy2_%0d", i), {31'd0, busy2}, (i <= 4) ? 1 : 0);
            chk($sformatf("kill_slot3_%0d", i), {29'd0, wdest[11:9]}, 0);
            chk($sformatf("kill_tagv3_%0d", i), {31'd0, tagv[3]}, 0);
        end

        // overflow: MUL issued into a busy lane-1 unit
        ready1 = 1; inst1 = mk(7'h03, 3'b000, 3'd4, 3'd3, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(); idle();
            if (i == 1) begin
                ready1 = 1; inst1 = mk(7'h02, 3'b000, 3'd6, 3'd2, 1'b1);
            end
            chk($sformatf("ovf_flag_%0d", i), {31'd0, ovf}, (i >= 2) ? 1 : 0);
            chk($sformatf("ovf_slot2_%0d", i), {29'd0, wdest[8:6]}, (i == LDIV) ? 3 : 0);
            chk($sformatf("ovf_tag2_%0d", i), {29'd0, tag4[8:6]}, (i == LDIV) ? 4 : 0);
        end
        rst_n = 0;
        step();
        rst_n = 1;
        chk("ovf_cleared", {31'd0, ovf}, 0);

        // val gating, then a no-destination fast uop on lane 2
        ready2 = 1; inst2 = mk(7'h00, 3'b000, 3'd1, 3'd5, 1'b0);
        step(); idle();
        chk("noval_wdest", {20'd0, wdest}, 0);
        chk("noval_tagv", {28'd0, tagv}, 0);
        ready2 = 1; inst2 = mk(7'h01, 3'b000, 3'd6, 3'd0, 1'b1);
        step(); idle();
        chk("nodest_slot1", {29'd0, wdest[5:3]}, 0);
        chk("nodest_tagv", {28'd0, tagv}, 4'b0010);
        chk("nodest_tag1", {29'd0, tag4[5:3]}, 6);

        // randomized traffic, busy lanes mostly steered to fast uops
        for (int n = 0; n < 3000; n++) begin
            logic [W-1:0] r [2];
            rst_n = ($urandom_range(0, 249) != 0);
            for (int l = 0; l < 2; l++) begin
                r[l] = W'($urandom());
                r[l][2] = ($urandom_range(0, 7) != 0);
                if (pend[l] && $urandom_range(0, 7) != 0) r[l][O_UOP + 1] = 1'b0;
            end
            inst1  = r[0];
            inst2  = r[1];
            ready1 = ($urandom_range(0, 3) != 0);
            ready2 = ($urandom_range(0, 3) != 0);
            brkill = ($urandom_range(0, 5) == 0) ? B'($urandom()) : '0;
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
